// File: rtl/ahb3lite_pkg.sv
// ahb3lite_pkg: shared AHB3-Lite encodings plus APB4 protection/strobe helpers.
// Contents: HTRANS/HSIZE/HRESP encodings, HPROT and PPROT bit positions,
// and pstrb(), which builds a size-aligned byte strobe from (hsize, address lsbs, bytes per beat).
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int HPROT_DATA       = 0;
    localparam int HPROT_PRIVILEGED = 1;

    localparam int PPROT_PRIVILEGED  = 0;
    localparam int PPROT_NONSECURE   = 1;
    localparam int PPROT_INSTRUCTION = 2;

    // Lane mask of 2^hsize bytes, shifted to the lane offset aligned down to the size.
    // Result is 64 lanes wide; callers keep the low bytes-per-beat bits.
    function automatic logic [63:0] pstrb(input logic [2:0] hsize, input logic [5:0] addr,
                                          input int unsigned bytes);
        logic [63:0] mask;
        logic [5:0]  off;
        mask = (64'd1 << (7'd1 << hsize)) - 64'd1;
        off  = addr & ~((6'd1 << hsize) - 6'd1) & 6'(bytes - 1);
        return mask << off;
    endfunction

endpackage

// File: rtl/ahb3lite_apb4_bridge.sv
// ahb3lite_apb4_bridge: AHB3-Lite slave to APB4 master bridge, one APB access per AHB beat.
// Ports: PCLK/PRESETn clock and async active-low reset; AHB slave side HSEL, HREADY, HADDR,
// HTRANS, HSIZE, HBURST, HPROT, HWRITE, HMASTLOCK, HWDATA in and HRDATA, HREADYOUT, HRESP out;
// APB master side PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT out and PRDATA, PREADY,
// PSLVERR in. Every output is a flop.
module ahb3lite_apb4_bridge
    import ahb3lite_pkg::*;
#(
    parameter int HADDR_SIZE = 32,
    parameter int PADDR_SIZE = 16,
    parameter int DATA_SIZE  = 32
) (
    input  logic                   PCLK,
    input  logic                   PRESETn,
    input  logic                   HSEL,
    input  logic [HADDR_SIZE-1:0]  HADDR,
    input  logic [DATA_SIZE-1:0]   HWDATA,
    output logic [DATA_SIZE-1:0]   HRDATA,
    input  logic                   HWRITE,
    input  logic [2:0]             HSIZE,
    input  logic [2:0]             HBURST,
    input  logic [3:0]             HPROT,
    input  logic [1:0]             HTRANS,
    input  logic                   HMASTLOCK,
    output logic                   HREADYOUT,
    input  logic                   HREADY,
    output logic                   HRESP,
    output logic                   PSEL,
    output logic                   PENABLE,
    output logic [PADDR_SIZE-1:0]  PADDR,
    output logic                   PWRITE,
    output logic [DATA_SIZE-1:0]   PWDATA,
    output logic [DATA_SIZE/8-1:0] PSTRB,
    output logic [2:0]             PPROT,
    input  logic [DATA_SIZE-1:0]   PRDATA,
    input  logic                   PREADY,
    input  logic                   PSLVERR
);

    localparam int STRB_W   = DATA_SIZE / 8;
    localparam int SIZE_MAX = $clog2(STRB_W);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t                state_q, state_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [PADDR_SIZE-1:0] paddr_q, paddr_d;
    logic [DATA_SIZE-1:0]  pwdata_q, pwdata_d;
    logic [STRB_W-1:0]     pstrb_q, pstrb_d;
    logic [2:0]            pprot_q, pprot_d;
    logic [DATA_SIZE-1:0]  hrdata_q, hrdata_d;
    logic                  hreadyout_q, hreadyout_d;
    logic                  hresp_q, hresp_d;
    logic                  accept, size_ok;
    logic [63:0]           strb_full;
    logic                  unused;

    assign unused = ^{HMASTLOCK, HBURST, HPROT[3:2], HADDR[HADDR_SIZE-1:PADDR_SIZE]};

    always_comb begin
        accept    = HSEL & HREADY & (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ) &
                    (state_q == ST_IDLE || state_q == ST_ERR2);
        size_ok   = HSIZE <= 3'(SIZE_MAX);
        strb_full = pstrb(HSIZE, HADDR[5:0], STRB_W);
        state_d   = state_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        pprot_d   = pprot_q;
        hrdata_d  = hrdata_q;
        case (state_q)
            ST_WDATA:  state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: state_d = !PREADY ? ST_ACCESS : PSLVERR ? ST_ERR1 : ST_IDLE;
            ST_ERR1:   state_d = ST_ERR2;
            default:   state_d = ST_IDLE;
        endcase
        // APB lines are loaded only for a legal access, so they never move under an active PSEL.
        if (accept) begin
            state_d = !size_ok ? ST_ERR1 : HWRITE ? ST_WDATA : ST_SETUP;
            if (size_ok) begin
                paddr_d                    = HADDR[PADDR_SIZE-1:0];
                pwrite_d                   = HWRITE;
                pstrb_d                    = HWRITE ? strb_full[STRB_W-1:0] : '0;
                pprot_d[PPROT_PRIVILEGED]  = HPROT[HPROT_PRIVILEGED];
                pprot_d[PPROT_NONSECURE]   = 1'b0;
                pprot_d[PPROT_INSTRUCTION] = ~HPROT[HPROT_DATA];
            end
        end
        if (state_q == ST_WDATA) pwdata_d = HWDATA;
        if (state_q == ST_ACCESS && PREADY && !PSLVERR && !pwrite_q) hrdata_d = PRDATA;
        // Outputs are decoded from the next state so they appear registered with the state.
        psel_d      = state_d == ST_SETUP || state_d == ST_ACCESS;
        penable_d   = state_d == ST_ACCESS;
        hreadyout_d = state_d == ST_IDLE || state_d == ST_ERR2;
        hresp_d     = (state_d == ST_ERR1 || state_d == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= ST_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            pprot_q     <= '0;
            hrdata_q    <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            pprot_q     <= pprot_d;
            hrdata_q    <= hrdata_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;
    assign PPROT     = pprot_q;
    assign HRDATA    = hrdata_q;
    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb3lite_apb4_bridge.sv
// tb_ahb3lite_apb4_bridge: scoreboard bench for the AHB3-Lite to APB4 bridge.
module tb_ahb3lite_apb4_bridge;
    import ahb3lite_pkg::*;

    typedef struct {int waits; logic resp; logic [31:0] rdata;} ahb_exp_t;
    typedef struct {logic [15:0] paddr; logic wr; logic [31:0] wdata; logic [3:0] strb; logic [2:0] prot;} apb_exp_t;
    typedef struct {int waits; logic err; logic [31:0] rdata;} slv_t;

    logic        pclk = 1'b0, presetn = 1'b1;
    logic        hsel, hwrite, hmastlock, hreadyout, hready, hresp;
    logic [31:0] haddr, hwdata, hrdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic        psel, penable, pwrite, pready, pslverr;
    logic [15:0] paddr;
    logic [31:0] pwdata, prdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;

    ahb_exp_t ahb_q[$];
    apb_exp_t apb_q[$];
    slv_t     slv_q[$];
    int       n_cmp = 0, n_err = 0;
    logic [31:0] last_rd = '0;

    assign hready = hreadyout;

    always #5 pclk = ~pclk;

    ahb3lite_apb4_bridge dut (
        .PCLK(pclk), .PRESETn(presetn), .HSEL(hsel), .HADDR(haddr), .HWDATA(hwdata),
        .HRDATA(hrdata), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
        .HTRANS(htrans), .HMASTLOCK(hmastlock), .HREADYOUT(hreadyout), .HREADY(hready),
        .HRESP(hresp), .PSEL(psel), .PENABLE(penable), .PADDR(paddr), .PWRITE(pwrite),
        .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot), .PRDATA(prdata), .PREADY(pready),
        .PSLVERR(pslverr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one AHB address phase in the first cycle with HREADYOUT high and records
    // what the bus and the APB side must show for it. Entered and left at posedge+1.
    task automatic issue(input logic sel, input logic [1:0] trans, input logic wr, input logic [2:0] size,
                         input logic [31:0] addr, input logic [3:0] prot, input logic [31:0] wdata,
                         input int waits, input logic err, input logic [31:0] rdata);
        int g, nb, base;
        ahb_exp_t ea;
        logic [3:0] strb;
        g = 0;
        while (!hreadyout) begin
            @(posedge pclk); #1;
            g++;
            if (g > 100) begin
                n_err++;
                $display("FAIL hreadyout_wait: got 0 for %0d cycles, expected 1", g);
                $fatal(1, "bus stalled");
            end
        end
        hsel = sel; htrans = trans; hwrite = wr; hsize = size; haddr = addr; hprot = prot;
        hburst = 3'($urandom); hmastlock = 1'($urandom);
        if (!(sel && trans[1])) ea = '{0, HRESP_OKAY, last_rd};
        else if (size > 3'd2) ea = '{1, HRESP_ERROR, last_rd};
        else begin
            nb = 1 << size;
            base = (int'(addr[1:0]) / nb) * nb;
            for (int b = 0; b < 4; b++) strb[b] = wr && b >= base && b < base + nb;
            apb_q.push_back('{addr[15:0], wr, wdata, strb, {~prot[0], 1'b0, prot[1]}});
            slv_q.push_back('{waits, err, rdata});
            if (!wr && !err) last_rd = rdata;
            ea = '{(wr ? 3 : 2) + waits + (err ? 1 : 0), err, last_rd};
        end
        ahb_q.push_back(ea);
        @(posedge pclk); #1;
        hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = wdata;
    endtask

    // APB slave: takes the next scripted response at SETUP and holds PREADY low for its wait count.
    slv_t cur;
    int   cnt;
    initial forever begin
        @(posedge pclk); #1;
        if (!presetn) begin
            pready = 1'b0; pslverr = 1'b0;
        end else if (psel && !penable) begin
            cur = slv_q.size() != 0 ? slv_q.pop_front() : '{0, 1'b0, 32'h0};
            cnt = cur.waits; pready = 1'b0; pslverr = 1'b0;
        end else if (psel && penable && cnt == 0) begin
            pready = 1'b1; pslverr = cur.err; prdata = cur.rdata;
        end else begin
            if (psel && penable) cnt--;
            pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
        end
    end

    // AHB monitor: measures each data phase and checks it against the scoreboard.
    int       dp_waits;
    logic     dp_open = 1'b0, dp_last_resp;
    ahb_exp_t ea_m;
    initial forever begin
        @(negedge pclk);
        if (!presetn) dp_open = 1'b0;
        else begin
            if (dp_open && !hreadyout) begin
                dp_waits++;
                dp_last_resp = hresp;
                if (dp_waits > 64) begin
                    n_cmp++; n_err++;
                    $display("FAIL ahb_timeout: got %0d wait cycles, expected completion", dp_waits);
                    if (ahb_q.size() != 0) void'(ahb_q.pop_front());
                    dp_open = 1'b0;
                end
            end else if (dp_open) begin
                if (ahb_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL ahb_unexpected: got a response, expected none");
                end else begin
                    ea_m = ahb_q.pop_front();
                    chk("ahb_waits", 64'(dp_waits), 64'(ea_m.waits));
                    chk("ahb_hresp", 64'(hresp), 64'(ea_m.resp));
                    chk("ahb_hrdata", 64'(hrdata), 64'(ea_m.rdata));
                    if (dp_waits > 0) chk("ahb_last_wait_hresp", 64'(dp_last_resp), 64'(ea_m.resp));
                end
                dp_open = 1'b0;
            end
            if (hreadyout && (hsel || htrans != HTRANS_IDLE)) begin
                dp_open = 1'b1; dp_waits = 0;
            end
        end
    end

    // APB monitor: checks each SETUP against the scoreboard and holds the lines stable in ACCESS.
    apb_exp_t    ep_m;
    logic [63:0] snap;
    logic        was_setup = 1'b0;
    initial forever begin
        @(negedge pclk);
        if (!presetn) was_setup = 1'b0;
        else begin
            chk("penable_without_psel", 64'(penable & ~psel), 64'd0);
            if (was_setup) chk("setup_then_access", 64'(psel & penable), 64'd1);
            if (psel && !penable) begin
                if (apb_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL apb_unexpected: got PSEL at PADDR 0x%0h, expected no access", paddr);
                end else begin
                    ep_m = apb_q.pop_front();
                    chk("apb_paddr", 64'(paddr), 64'(ep_m.paddr));
                    chk("apb_pwrite", 64'(pwrite), 64'(ep_m.wr));
                    chk("apb_pstrb", 64'(pstrb), 64'(ep_m.strb));
                    chk("apb_pprot", 64'(pprot), 64'(ep_m.prot));
                    if (ep_m.wr) chk("apb_pwdata", 64'(pwdata), 64'(ep_m.wdata));
                end
                snap = 64'({paddr, pwrite, pwdata, pstrb, pprot});
            end else if (psel && penable) chk("apb_stable", 64'({paddr, pwrite, pwdata, pstrb, pprot}), snap);
            was_setup = psel & ~penable;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected completion within time limit");
        $fatal(1, "watchdog");
    end

    int   g, k;
    logic rw;
    initial begin
        hsel = 0; htrans = HTRANS_IDLE; haddr = 0; hwrite = 0; hsize = 0; hburst = 0; hprot = 0;
        hmastlock = 0; hwdata = 0; pready = 0; pslverr = 0; prdata = 0;
        #1 presetn = 1'b0;
        #11;
        chk("rst_psel", 64'(psel), 64'd0);
        chk("rst_penable", 64'(penable), 64'd0);
        chk("rst_pwrite", 64'(pwrite), 64'd0);
        chk("rst_paddr", 64'(paddr), 64'd0);
        chk("rst_pwdata", 64'(pwdata), 64'd0);
        chk("rst_pstrb", 64'(pstrb), 64'd0);
        chk("rst_pprot", 64'(pprot), 64'd0);
        chk("rst_hrdata", 64'(hrdata), 64'd0);
        chk("rst_hreadyout", 64'(hreadyout), 64'd1);
        chk("rst_hresp", 64'(hresp), 64'd0);
        @(negedge pclk); #2;
        presetn = 1'b1;
        @(posedge pclk); #1;
        issue(1, HTRANS_NONSEQ, 0, 3'd2, 32'h0000_0104, 4'h3, 32'h0, 0, 0, 32'hDEADBEEF);
        issue(1, HTRANS_NONSEQ, 1, 3'd0, 32'h0000_0013, 4'h1, 32'h00AB_0000, 0, 0, 32'h0);
        issue(1, HTRANS_SEQ, 1, 3'd2, 32'h0000_2468, 4'h2, 32'hCAFE_F00D, 3, 0, 32'h0);
        issue(1, HTRANS_NONSEQ, 0, 3'd1, 32'h0000_0042, 4'h0, 32'h0, 1, 1, 32'h1111_2222);
        issue(1, HTRANS_NONSEQ, 0, 3'd2, 32'h0000_0300, 4'h3, 32'h0, 0, 0, 32'h3333_4444);
        issue(1, HTRANS_NONSEQ, 1, 3'd3, 32'h0000_0008, 4'h3, 32'h5555_6666, 0, 0, 32'h0);
        issue(1, HTRANS_BUSY, 0, 3'd2, 32'h0000_0010, 4'h3, 32'h0, 0, 0, 32'h0);
        issue(0, HTRANS_NONSEQ, 1, 3'd2, 32'h0000_0020, 4'h3, 32'h0, 0, 0, 32'h0);
        for (int i = 0; i < 170; i++) begin
            if (i == 150) begin
                issue(1, HTRANS_NONSEQ, 0, 3'd2, 32'h0000_0200, 4'h3, 32'h0, 6, 0, 32'h1234_5678);
                g = 0;
                while (!(psel && penable) && g < 20) begin
                    @(posedge pclk); #1;
                    g++;
                end
                chk("rst_mid_in_access", 64'(psel & penable), 64'd1);
                @(negedge pclk); #2;
                presetn = 1'b0;
                #1;
                chk("rst_mid_psel", 64'(psel), 64'd0);
                chk("rst_mid_penable", 64'(penable), 64'd0);
                chk("rst_mid_hreadyout", 64'(hreadyout), 64'd1);
                chk("rst_mid_hresp", 64'(hresp), 64'd0);
                ahb_q.delete(); apb_q.delete(); slv_q.delete(); last_rd = '0;
                @(negedge pclk); @(negedge pclk); #2;
                presetn = 1'b1;
                @(posedge pclk); #1;
            end
            k = $urandom_range(0, 9);
            rw = 1'($urandom);
            if (k == 0)
                issue(0, {1'b1, 1'($urandom)}, rw, 3'd2, $urandom, 4'($urandom), $urandom, 0, 0, 0);
            else if (k == 1)
                issue(1, {1'b0, 1'($urandom)}, rw, 3'd2, $urandom, 4'($urandom), $urandom, 0, 0, 0);
            else if (k == 2)
                issue(1, HTRANS_NONSEQ, rw, 3'($urandom_range(3, 7)), $urandom, 4'($urandom), $urandom, 0, 0, 0);
            else
                issue(1, {1'b1, 1'($urandom)}, rw, 3'($urandom_range(0, 2)), $urandom, 4'($urandom),
                      $urandom, $urandom_range(0, 3), $urandom_range(0, 5) == 0, $urandom);
        end
        g = 0;
        while ((ahb_q.size() != 0 || apb_q.size() != 0) && g < 100) begin
            @(posedge pclk); #1;
            g++;
        end
        chk("ahb_queue_drained", 64'(ahb_q.size()), 64'd0);
        chk("apb_queue_drained", 64'(apb_q.size()), 64'd0);
        @(negedge pclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
